gnn_aggregate: RTL and testbench

GNN_AGGREGATE -- requirements
Module: gnn_aggregate

---
 rtl/gnn_aggregate.sv | 173 +++++++++++++++++
 tb/tb_gnn_aggregate.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gnn_aggregate.sv
// gnn_aggregate: neighbour-sum aggregation over a 4-node graph, 4 features per node.
// One source node is folded into every destination's accumulators per cycle, so a
// pass takes 4 ACCUM cycles. Results are presented to dnn_nodes with a ready level.
module gnn_aggregate #(
  parameter int FEAT_W    = 16,
  parameter int SELF_LOOP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [15:0]              adj,
  input  logic signed [FEAT_W-1:0] h0_n0,
  input  logic signed [FEAT_W-1:0] h1_n0,
  input  logic signed [FEAT_W-1:0] h2_n0,
  input  logic signed [FEAT_W-1:0] h3_n0,
  input  logic signed [FEAT_W-1:0] h0_n1,
  input  logic signed [FEAT_W-1:0] h1_n1,
  input  logic signed [FEAT_W-1:0] h2_n1,
  input  logic signed [FEAT_W-1:0] h3_n1,
  input  logic signed [FEAT_W-1:0] h0_n2,
  input  logic signed [FEAT_W-1:0] h1_n2,
  input  logic signed [FEAT_W-1:0] h2_n2,
  input  logic signed [FEAT_W-1:0] h3_n2,
  input  logic signed [FEAT_W-1:0] h0_n3,
  input  logic signed [FEAT_W-1:0] h1_n3,
  input  logic signed [FEAT_W-1:0] h2_n3,
  input  logic signed [FEAT_W-1:0] h3_n3,
  output logic signed [20:0]       x0_dnn_n0,
  output logic signed [20:0]       x1_dnn_n0,
  output logic signed [20:0]       x2_dnn_n0,
  output logic signed [20:0]       x3_dnn_n0,
  output logic signed [20:0]       x0_dnn_n1,
  output logic signed [20:0]       x1_dnn_n1,
  output logic signed [20:0]       x2_dnn_n1,
  output logic signed [20:0]       x3_dnn_n1,
  output logic signed [20:0]       x0_dnn_n2,
  output logic signed [20:0]       x1_dnn_n2,
  output logic signed [20:0]       x2_dnn_n2,
  output logic signed [20:0]       x3_dnn_n2,
  output logic signed [20:0]       x0_dnn_n3,
  output logic signed [20:0]       x1_dnn_n3,
  output logic signed [20:0]       x2_dnn_n3,
  output logic signed [20:0]       x3_dnn_n3,
  output logic                     in_dnn_ready,
  output logic                     busy
);

  localparam int ACC_W = 21;

  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [FEAT_W-1:0] feat_t;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  j_q, j_d;
  logic [15:0] adj_q, adj_d;

  // All arrays are indexed [node][feature]
  feat_t h_in  [4][4];
  feat_t h_q   [4][4];
  feat_t h_d   [4][4];
  acc_t  acc_q [4][4];
  acc_t  acc_d [4][4];
  acc_t  x_q   [4][4];
  acc_t  x_d   [4][4];
  acc_t  sum   [4][4];
  logic  take  [4];

  assign h_in[0][0] = h0_n0;
  assign h_in[0][1] = h1_n0;
  assign h_in[0][2] = h2_n0;
  assign h_in[0][3] = h3_n0;
  assign h_in[1][0] = h0_n1;
  assign h_in[1][1] = h1_n1;
  assign h_in[1][2] = h2_n1;
  assign h_in[1][3] = h3_n1;
  assign h_in[2][0] = h0_n2;
  assign h_in[2][1] = h1_n2;
  assign h_in[2][2] = h2_n2;
  assign h_in[2][3] = h3_n2;
  assign h_in[3][0] = h0_n3;
  assign h_in[3][1] = h1_n3;
  assign h_in[3][2] = h2_n3;
  assign h_in[3][3] = h3_n3;

  // Partial sums: each destination adds source j's features when it selects source j
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      take[i] = adj_q[{2'(i), j_q}] || ((SELF_LOOP != 0) && (2'(i) == j_q));
      for (int f = 0; f < 4; f++) begin
        sum[i][f] = acc_q[i][f] + (take[i] ? acc_t'(h_q[j_q][f]) : acc_t'(0));
      end
    end
  end

  // Next-state logic: latch inputs on start, step through sources, publish on the last one
  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    adj_d   = adj_q;
    h_d     = h_q;
    acc_d   = acc_q;
    x_d     = x_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = ACCUM;
          j_d     = 2'd0;
          adj_d   = adj;
          h_d     = h_in;
          for (int i = 0; i < 4; i++) begin
            for (int f = 0; f < 4; f++) begin
              acc_d[i][f] = '0;
            end
          end
        end
      end
      ACCUM: begin
        acc_d = sum;
        j_d   = j_q + 2'd1;
        if (j_q == 2'd3) begin
          x_d     = sum;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched operands, accumulators and published results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      adj_q   <= '0;
      for (int i = 0; i < 4; i++) begin
        for (int f = 0; f < 4; f++) begin
          h_q[i][f]   <= '0;
          acc_q[i][f] <= '0;
          x_q[i][f]   <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      adj_q   <= adj_d;
      h_q     <= h_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

  assign busy         = (state_q == ACCUM);
  assign in_dnn_ready = (state_q == DONE);

  assign x0_dnn_n0 = x_q[0][0];
  assign x1_dnn_n0 = x_q[0][1];
  assign x2_dnn_n0 = x_q[0][2];
  assign x3_dnn_n0 = x_q[0][3];
  assign x0_dnn_n1 = x_q[1][0];
  assign x1_dnn_n1 = x_q[1][1];
  assign x2_dnn_n1 = x_q[1][2];
  assign x3_dnn_n1 = x_q[1][3];
  assign x0_dnn_n2 = x_q[2][0];
  assign x1_dnn_n2 = x_q[2][1];
  assign x2_dnn_n2 = x_q[2][2];
  assign x3_dnn_n2 = x_q[2][3];
  assign x0_dnn_n3 = x_q[3][0];
  assign x1_dnn_n3 = x_q[3][1];
  assign x2_dnn_n3 = x_q[3][2];
  assign x3_dnn_n3 = x_q[3][3];

endmodule

// File: tb/tb_gnn_aggregate.sv
// tb_gnn_aggregate: drives two instances (with and without self loops) from the same
// inputs and checks both against a graph-sum model every cycle, plus literal results.
module tb_gnn_aggregate;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [15:0] adj = 16'h0000;
  logic signed [15:0] h [4][4];
  logic signed [20:0] xa [4][4];
  logic signed [20:0] xb [4][4];
  logic ready_a, busy_a, ready_b, busy_b;

  int n_compared = 0;
  int n_mismatched = 0;
  bit checking = 1'b0;

  // Model state: index 0 = self-loop instance, 1 = no self loop; [node][feature]
  int exp_x [2][4][4];
  int pend  [2][4][4];
  int cnt = 0;
  int exp_ready = 0;

  always #5 clk = ~clk;

  gnn_aggregate #(.FEAT_W(16), .SELF_LOOP(1)) dut_sl (
    .clk(clk), .rst(rst), .start(start), .adj(adj),
    .h0_n0(h[0][0]), .h1_n0(h[0][1]), .h2_n0(h[0][2]), .h3_n0(h[0][3]),
    .h0_n1(h[1][0]), .h1_n1(h[1][1]), .h2_n1(h[1][2]), .h3_n1(h[1][3]),
    .h0_n2(h[2][0]), .h1_n2(h[2][1]), .h2_n2(h[2][2]), .h3_n2(h[2][3]),
    .h0_n3(h[3][0]), .h1_n3(h[3][1]), .h2_n3(h[3][2]), .h3_n3(h[3][3]),
    .x0_dnn_n0(xa[0][0]), .x1_dnn_n0(xa[0][1]), .x2_dnn_n0(xa[0][2]), .x3_dnn_n0(xa[0][3]),
    .x0_dnn_n1(xa[1][0]), .x1_dnn_n1(xa[1][1]), .x2_dnn_n1(xa[1][2]), .x3_dnn_n1(xa[1][3]),
    .x0_dnn_n2(xa[2][0]), .x1_dnn_n2(xa[2][1]), .x2_dnn_n2(xa[2][2]), .x3_dnn_n2(xa[2][3]),
    .x0_dnn_n3(xa[3][0]), .x1_dnn_n3(xa[3][1]), .x2_dnn_n3(xa[3][2]), .x3_dnn_n3(xa[3][3]),
    .in_dnn_ready(ready_a), .busy(busy_a)
  );

  gnn_aggregate #(.FEAT_W(16), .SELF_LOOP(0)) dut_ns (
    .clk(clk), .rst(rst), .start(start), .adj(adj),
    .h0_n0(h[0][0]), .h1_n0(h[0][1]), .h2_n0(h[0][2]), .h3_n0(h[0][3]),
    .h0_n1(h[1][0]), .h1_n1(h[1][1]), .h2_n1(h[1][2]), .h3_n1(h[1][3]),
    .h0_n2(h[2][0]), .h1_n2(h[2][1]), .h2_n2(h[2][2]), .h3_n2(h[2][3]),
    .h0_n3(h[3][0]), .h1_n3(h[3][1]), .h2_n3(h[3][2]), .h3_n3(h[3][3]),
    .x0_dnn_n0(xb[0][0]), .x1_dnn_n0(xb[0][1]), .x2_dnn_n0(xb[0][2]), .x3_dnn_n0(xb[0][3]),
    .x0_dnn_n1(xb[1][0]), .x1_dnn_n1(xb[1][1]), .x2_dnn_n1(xb[1][2]), .x3_dnn_n1(xb[1][3]),
    .x0_dnn_n2(xb[2][0]), .x1_dnn_n2(xb[2][1]), .x2_dnn_n2(xb[2][2]), .x3_dnn_n2(xb[2][3]),
    .x0_dnn_n3(xb[3][0]), .x1_dnn_n3(xb[3][1]), .x2_dnn_n3(xb[3][2]), .x3_dnn_n3(xb[3][3]),
    .in_dnn_ready(ready_b), .busy(busy_b)
  );

  // Graph aggregation: sum of feature f over every source feeding destination i
  function automatic int agg(input int d, input int i, input int f);
    int s;
    s = 0;
    for (int j = 0; j < 4; j++) begin
      if (adj[4'(4 * i + j)] || (d == 0 && i == j)) s += int'(h[j][f]);
    end
    return s;
  endfunction

  function automatic int getX(input int d, input int i, input int f);
    return (d == 0) ? int'(xa[i][f]) : int'(xb[i][f]);
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input int d, input int i, input int f, input int exp);
    checkVal($sformatf("dut%0d x%0d_n%0d", d, f, i), getX(d, i, f), exp);
    checkVal($sformatf("model%0d x%0d_n%0d", d, f, i), exp_x[d][i][f], exp);
  endtask

  task automatic checkCtrl(input int exp_rdy, input int exp_busy);
    checkVal("dut0 ready", int'(ready_a), exp_rdy);
    checkVal("dut1 ready", int'(ready_b), exp_rdy);
    checkVal("dut0 busy", int'(busy_a), exp_busy);
    checkVal("dut1 busy", int'(busy_b), exp_busy);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Start pulse covering exactly one rising edge; returns at the falling edge after it
  task automatic applyStimulus(input logic [15:0] a);
    adj = a;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Transaction-level model: a pass accepted when idle completes 4 edges later
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt = 0;
      exp_ready = 0;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++)
          for (int f = 0; f < 4; f++) exp_x[d][i][f] = 0;
    end else if (cnt == 0) begin
      if (start) begin
        for (int d = 0; d < 2; d++)
          for (int i = 0; i < 4; i++)
            for (int f = 0; f < 4; f++) pend[d][i][f] = agg(d, i, f);
        cnt = 4;
        exp_ready = 0;
      end
    end else begin
      cnt--;
      if (cnt == 0) begin
        exp_x = pend;
        exp_ready = 1;
      end
    end
  end

  // Every falling edge: both instances must match the model
  always @(negedge clk) begin
    if (checking) begin
      checkVal("cyc dut0 ready", int'(ready_a), exp_ready);
      checkVal("cyc dut1 ready", int'(ready_b), exp_ready);
      checkVal("cyc dut0 busy", int'(busy_a), (cnt != 0) ? 1 : 0);
      checkVal("cyc dut1 busy", int'(busy_b), (cnt != 0) ? 1 : 0);
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < 4; i++)
          for (int f = 0; f < 4; f++)
            checkVal($sformatf("cyc dut%0d x%0d_n%0d", d, f, i), getX(d, i, f), exp_x[d][i][f]);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int pulses;
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'sd0;

    // Asynchronous reset: outputs clear before any clock edge
    #1 rst = 1'b1;
    #2;
    checkCtrl(0, 0);
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 4; n++)
        for (int f = 0; f < 4; f++) checkOutput(d, n, f, 0);
    checking = 1'b1;
    waitCycles(2);
    rst = 1'b0;
    waitCycles(2);
    checkCtrl(0, 0);

    // Identity through self loops; no-self-loop instance has no sources
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'(10 * n + f);
    applyStimulus(16'h0000);
    waitCycles(3);
    checkCtrl(0, 1);
    waitCycles(1);
    checkCtrl(1, 0);
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) begin
        checkOutput(0, n, f, 10 * n + f);
        checkOutput(1, n, f, 0);
      end
    waitCycles(2);
    checkCtrl(1, 0);

    // Re-run from DONE: ready drops, old results held until the new load
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'(-(10 * n + f) - 1);
    applyStimulus(16'h0000);
    checkCtrl(0, 1);
    checkOutput(0, 3, 3, 33);
    waitCycles(3);
    checkOutput(0, 3, 3, 33);
    checkCtrl(0, 1);
    waitCycles(1);
    checkCtrl(1, 0);
    checkOutput(0, 3, 3, -34);
    checkOutput(0, 0, 0, -1);
    checkOutput(0, 2, 1, -22);

    // Full graph at the most negative feature value
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'(-32768);
    applyStimulus(16'hFFFF);
    waitCycles(4);
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 4; n++)
        for (int f = 0; f < 4; f++) checkOutput(d, n, f, -131072);

    // Sparse: single edge 1 -> 0
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'sd0;
    h[1][0] = 16'sd5;
    h[0][0] = 16'sd7;
    applyStimulus(16'h0002);
    waitCycles(4);
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) checkOutput(1, n, f, (n == 0 && f == 0) ? 5 : 0);
    checkOutput(0, 0, 0, 12);
    checkOutput(0, 1, 0, 5);
    checkOutput(0, 2, 0, 0);

    // Second start two edges into a pass is ignored, along with the new features
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'(4 * n + f + 1);
    applyStimulus(16'h00F0);
    waitCycles(1);
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'sd1000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitCycles(1);
    checkCtrl(0, 1);
    waitCycles(1);
    checkCtrl(1, 0);
    checkOutput(1, 1, 0, 28);
    checkOutput(1, 1, 3, 40);
    checkOutput(1, 0, 0, 0);
    checkOutput(0, 2, 1, 10);
    checkOutput(0, 1, 2, 36);
    waitCycles(1);
    checkCtrl(1, 0);

    // Reset between edges T+2 and T+3 aborts the pass immediately
    applyStimulus(16'hFFFF);
    waitCycles(2);
    #2 rst = 1'b1;
    #1;
    checkCtrl(0, 0);
    for (int d = 0; d < 2; d++)
      for (int n = 0; n < 4; n++)
        for (int f = 0; f < 4; f++) checkOutput(d, n, f, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    waitCycles(6);
    checkCtrl(0, 0);
    checkOutput(0, 1, 1, 0);

    // Start held high: one completed pass every 5 cycles
    for (int n = 0; n < 4; n++)
      for (int f = 0; f < 4; f++) h[n][f] = 16'(10 * n + f);
    adj = 16'hFFFF;
    start = 1'b1;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (ready_a) pulses++;
    end
    start = 1'b0;
    checkVal("back-to-back ready cycles", pulses, 3);
    checkOutput(0, 2, 3, 72);
    checkOutput(1, 0, 0, 60);
    waitCycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
